// File: rtl/reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_ctrl
// Brief    : 4-entry writeback FIFO between ALU/load units and the register
//            file write port. It has a pending-write scoreboard, and the
//            optional data bypass is enabled by the WB_BYPASS_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module reg_writeback_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        port_hold,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    input  logic [4:0]  rd_query1,
    input  logic [4:0]  rd_query2,
    output logic        pending1,
    output logic        pending2,
    output logic        fwd_valid1,
    output logic        fwd_valid2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2
);

    logic [4:0]  r_rd   [0:3];
    logic [31:0] r_data [0:3];
    logic [3:0]  r_vld;
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_mem_acc;
    logic        w_alu_acc;
    logic [4:0]  w_acc_rd;
    logic [31:0] w_acc_data;
    logic        w_push;
    logic        w_pop;

    assign w_full  = (r_count == 3'd4);
    assign w_empty = (r_count == 3'd0);

    // Loads win a simultaneous request; ready never looks at alu_valid.
    assign mem_ready  = !w_full;
    assign alu_ready  = !w_full && !mem_valid;
    assign w_mem_acc  = mem_valid && mem_ready;
    assign w_alu_acc  = alu_valid && alu_ready;
    assign w_acc_rd   = w_mem_acc ? mem_rd   : alu_rd;
    assign w_acc_data = w_mem_acc ? mem_data : alu_data;
    assign w_push     = (w_mem_acc || w_alu_acc) && (w_acc_rd != 5'd0);
    assign w_pop      = RegWrite;

    assign RegWrite      = !rst && !w_empty && !port_hold;
    assign WriteRegister = (rst || w_empty) ? 5'd0  : r_rd[r_rptr];
    assign WriteData     = (rst || w_empty) ? 32'd0 : r_data[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_vld   <= 4'd0;
        end else begin
            if (w_pop) begin
                r_rptr        <= r_rptr + 2'd1;
                r_vld[r_rptr] <= 1'b0;
            end
            if (w_push) begin
                r_wptr        <= r_wptr + 2'd1;
                r_vld[r_wptr] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by r_vld.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= w_acc_rd;
            r_data[r_wptr] <= w_acc_data;
        end
    end

    logic       w_hit1;
    logic       w_hit2;
    logic [1:0] w_sidx;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_sidx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_sidx = r_rptr + 2'(i);
            if (r_vld[w_sidx] && (r_rd[w_sidx] == rd_query1)) w_hit1 = 1'b1;
            if (r_vld[w_sidx] && (r_rd[w_sidx] == rd_query2)) w_hit2 = 1'b1;
        end
    end

    assign pending1 = !rst && (rd_query1 != 5'd0) && w_hit1;
    assign pending2 = !rst && (rd_query2 != 5'd0) && w_hit2;

`ifdef WB_BYPASS_EN
    logic [31:0] w_fd1;
    logic [31:0] w_fd2;
    logic [1:0]  w_bidx;

    // Walk oldest to newest so the youngest matching entry wins.
    always_comb begin
        w_fd1  = 32'd0;
        w_fd2  = 32'd0;
        w_bidx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_bidx = r_rptr + 2'(i);
            if (r_vld[w_bidx] && (r_rd[w_bidx] == rd_query1)) w_fd1 = r_data[w_bidx];
            if (r_vld[w_bidx] && (r_rd[w_bidx] == rd_query2)) w_fd2 = r_data[w_bidx];
        end
    end

    assign fwd_valid1 = pending1;
    assign fwd_valid2 = pending2;
    assign fwd_data1  = pending1 ? w_fd1 : 32'd0;
    assign fwd_data2  = pending2 ? w_fd2 : 32'd0;
`else
    assign fwd_valid1 = 1'b0;
    assign fwd_valid2 = 1'b0;
    assign fwd_data1  = 32'd0;
    assign fwd_data2  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_ctrl
// Brief    : Bench for reg_writeback_ctrl. It runs directed scenarios and then
//            random traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, port_hold;
    logic [4:0]  alu_rd, mem_rd, rd_query1, rd_query2;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData, fwd_data1, fwd_data2;
    logic        pending1, pending2, fwd_valid1, fwd_valid2;

    reg_writeback_ctrl dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .port_hold(port_hold),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .rd_query1(rd_query1), .rd_query2(rd_query2),
        .pending1(pending1), .pending2(pending2),
        .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the FIFO contents as plain queues, head at index 0.
    logic [4:0]  q_rd[$];
    logic [31:0] q_d[$];
    logic        acc_mem, acc_alu, exp_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic        full, empty, rw, p1, p2;
        logic [31:0] wr, wd, fd1, fd2;
        if (rst) begin
            q_rd.delete();
            q_d.delete();
        end
        full  = (q_rd.size() == 4);
        empty = (q_rd.size() == 0);
        rw    = !rst && !empty && !port_hold;
        wr = 32'd0;
        wd = 32'd0;
        if (!rst && !empty) begin
            wr = {27'd0, q_rd[0]};
            wd = q_d[0];
        end
        p1 = 1'b0; p2 = 1'b0; fd1 = 32'd0; fd2 = 32'd0;
        foreach (q_rd[k]) begin
            if (rd_query1 != 5'd0 && q_rd[k] == rd_query1) begin p1 = 1'b1; fd1 = q_d[k]; end
            if (rd_query2 != 5'd0 && q_rd[k] == rd_query2) begin p2 = 1'b1; fd2 = q_d[k]; end
        end
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, !full});
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, !full && !mem_valid});
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, rw});
        chk("WriteRegister", {27'd0, WriteRegister}, wr);
        chk("WriteData", WriteData, wd);
        chk("pending1", {31'd0, pending1}, {31'd0, p1});
        chk("pending2", {31'd0, pending2}, {31'd0, p2});
`ifdef WB_BYPASS_EN
        chk("fwd_valid1", {31'd0, fwd_valid1}, {31'd0, p1});
        chk("fwd_valid2", {31'd0, fwd_valid2}, {31'd0, p2});
        chk("fwd_data1", fwd_data1, fd1);
        chk("fwd_data2", fwd_data2, fd2);
`else
        chk("fwd_valid1", {31'd0, fwd_valid1}, 32'd0);
        chk("fwd_valid2", {31'd0, fwd_valid2}, 32'd0);
        chk("fwd_data1", fwd_data1, 32'd0);
        chk("fwd_data2", fwd_data2, 32'd0);
`endif
        acc_mem = mem_valid && !full;
        acc_alu = alu_valid && !full && !mem_valid;
        exp_pop = rw;
    endtask

    // Inputs are set after a falling edge; one call covers one clock cycle.
    task automatic tick();
        #2;
        compare_all();
        @(posedge clk);
        if (rst) begin
            q_rd.delete();
            q_d.delete();
        end else begin
            if (exp_pop) begin
                void'(q_rd.pop_front());
                void'(q_d.pop_front());
            end
            if (acc_mem && mem_rd != 5'd0) begin
                q_rd.push_back(mem_rd); q_d.push_back(mem_data);
            end else if (acc_alu && alu_rd != 5'd0) begin
                q_rd.push_back(alu_rd); q_d.push_back(alu_data);
            end
        end
        @(negedge clk);
        if (acc_mem) mem_valid = 1'b0;
        if (acc_alu) alu_valid = 1'b0;
    endtask

    task automatic alu_req(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    initial begin
        int nxt;
        rst = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0; port_hold = 1'b0;
        alu_rd = 5'd0; mem_rd = 5'd0; alu_data = 32'd0; mem_data = 32'd0;
        rd_query1 = 5'd0; rd_query2 = 5'd0;
        @(negedge clk);
        #1;
        chk("reset_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("reset_WriteData", WriteData, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single ALU write with one-cycle latency.
        alu_req(5'd5, 32'h12345678);
        tick();
        #1;
        chk("req026_RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("req026_WriteRegister", {27'd0, WriteRegister}, 32'd5);
        chk("req026_WriteData", WriteData, 32'h12345678);
        tick();
        #1;
        chk("req026_RegWrite_after", {31'd0, RegWrite}, 32'd0);
        tick();

        // Simultaneous requests: the load goes first.
        alu_req(5'd3, 32'h33);
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
        #1;
        chk("req027_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("req027_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        #1;
        chk("req027_first_wr", {27'd0, WriteRegister}, 32'd4);
        tick();
        #1;
        chk("req027_second_wr", {27'd0, WriteRegister}, 32'd3);
        tick();
        tick();

        // Hold the write port while five back-to-back requests arrive.
        port_hold = 1'b1;
        nxt = 1;
        for (int c = 0; c < 6; c++) begin
            if (!alu_valid && nxt <= 5) begin
                alu_req(5'(nxt), 32'h100 + nxt);
                nxt++;
            end
            if (c >= 4) begin
                #1;
                chk("req028_ready_full", {31'd0, alu_ready}, 32'd0);
            end
            tick();
        end
        port_hold = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("req028_order", {27'd0, WriteRegister}, 32'(c + 1));
            tick();
        end
        tick();

        // Writes to register 0 are acknowledged and then dropped.
        alu_req(5'd0, 32'hFFFFFFFF);
        #1;
        chk("req029_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        #1;
        chk("req029_RegWrite", {31'd0, RegWrite}, 32'd0);
        tick();

        // Two queued writes to one register: newest data is forwarded.
        port_hold = 1'b1; rd_query1 = 5'd7;
        alu_req(5'd7, 32'hA);
        tick();
        alu_req(5'd7, 32'hB);
        tick();
        #1;
        chk("req030_pending1", {31'd0, pending1}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("req030_fwd_data1", fwd_data1, 32'hB);
`else
        chk("req030_fwd_valid1", {31'd0, fwd_valid1}, 32'd0);
`endif
        port_hold = 1'b0;
        #1;
        chk("req030_first_data", WriteData, 32'hA);
        tick();
        tick();
        #1;
        chk("req030_pending1_drained", {31'd0, pending1}, 32'd0);
        tick();

        // Asynchronous reset with three entries queued.
        port_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            alu_req(5'(9 + c), 32'h900 + c);
            tick();
        end
        rd_query1 = 5'd9; rd_query2 = 5'd11; port_hold = 1'b0;
        #1;
        chk("req031_RegWrite_pre", {31'd0, RegWrite}, 32'd1);
        chk("req031_pending2_pre", {31'd0, pending2}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("req031_RegWrite_rst", {31'd0, RegWrite}, 32'd0);
        chk("req031_pending1_rst", {31'd0, pending1}, 32'd0);
        chk("req031_pending2_rst", {31'd0, pending2}, 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("req031_no_stale", {31'd0, RegWrite}, 32'd0);
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!alu_valid && ($urandom_range(0, 99) < 45)) begin
                alu_req(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            end
            if (!mem_valid && ($urandom_range(0, 99) < 30)) begin
                mem_valid = 1'b1;
                mem_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mem_data  = $urandom;
            end
            port_hold = ($urandom_range(0, 99) < 35);
            if (q_rd.size() > 0 && $urandom_range(0, 1) == 1)
                rd_query1 = q_rd[$urandom_range(0, q_rd.size() - 1)];
            else
                rd_query1 = 5'($urandom_range(0, 31));
            if (q_rd.size() > 0 && $urandom_range(0, 1) == 1)
                rd_query2 = q_rd[q_rd.size() - 1];
            else
                rd_query2 = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 249) == 0);
            tick();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock (only clock).
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: alu_valid/alu_rd/alu_data  input  1/5/32  ALU writeback request; alu_ready  output  1.
REQ-004 SHALL have: mem_valid/mem_rd/mem_data  input  1/5/32  load writeback request; mem_ready  output  1.
REQ-005 SHALL have: port_hold  input  1  register-file write port unavailable this cycle.
REQ-006 SHALL have: RegWrite/WriteRegister/WriteData  output  1/5/32  drive register-file write port.
REQ-007 SHALL have: rd_query1/rd_query2  input  5  scoreboard query; pending1/pending2  output  1  write to queried register still queued.
REQ-008 SHALL have: fwd_valid1/fwd_valid2  output  1, fwd_data1/fwd_data2  output  32  bypass of queued data.

Function
REQ-009 SHALL buffer requests in a 4-entry FIFO (rd, data), circular read/write pointers with wrap 3->0, 3-bit occupancy count 0..4.
REQ-010 SHALL accept at most one request per clock; handshake completes at the edge where valid and ready are both high.
REQ-011 mem_ready SHALL equal !full; alu_ready SHALL equal !full && !mem_valid (load priority on simultaneous requests).
REQ-012 ready SHALL depend only on FIFO state and mem_valid, never on alu_valid; a requester SHALL hold valid/rd/data stable until accepted.
REQ-013 An accepted request with rd==0 SHALL complete the handshake but SHALL NOT be enqueued.
REQ-014 RegWrite SHALL equal !empty && !port_hold; WriteRegister/WriteData SHALL show FIFO head; WriteRegister/WriteData SHALL be 0 when empty.
REQ-015 Head SHALL pop at each rising edge where RegWrite is high; port_hold high SHALL freeze the head.
REQ-016 Latency: request accepted at edge N into empty FIFO SHALL appear on write port during cycle N..N+1 and be committed by the register file at edge N+1 (absent port_hold).
REQ-017 Simultaneous push and pop SHALL leave count unchanged; push while full SHALL be impossible (ready low); pop while empty SHALL not occur.
REQ-018 pendingK SHALL be 1 iff rd_queryK != 0 and matches rd of any occupied FIFO entry; combinational.
REQ-019 Multiple queued writes to one register SHALL commit in acceptance order.

Reset
REQ-020 rst high SHALL immediately clear pointers, count, and all FIFO valid state; RegWrite, pending1/2, fwd_valid1/2 SHALL read 0; data outputs 0.
REQ-021 Reset mid-drain SHALL discard all queued entries; no RegWrite SHALL assert until a new request is accepted after rst falls.
REQ-022 FIFO data storage SHALL need no reset; only control state is reset.

Configuration
REQ-023 Macro WB_BYPASS_EN SHALL control forwarding.
REQ-024 With WB_BYPASS_EN defined: fwd_validK SHALL equal pendingK; fwd_dataK SHALL be data of the newest matching occupied entry.
REQ-025 Without WB_BYPASS_EN: fwd_validK and fwd_dataK SHALL be tied to 0; pendingK unaffected.

Verification
REQ-026 Single ALU request rd=5 data=0x12345678, port_hold=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0x12345678 for exactly one cycle; FIFO empty after.
REQ-027 alu_valid and mem_valid both high (rd=3 / rd=4) -> mem accepted first, alu_ready=0 that cycle; writes appear 4 then 3 on consecutive cycles.
REQ-028 port_hold=1 for 6 cycles with 5 back-to-back requests rd=1..5 -> 4 accepted, ready low on 5th; after release writes 1,2,3,4 in order, then 5 accepted and written.
REQ-029 Request rd=0 data=0xFFFFFFFF -> handshake completes, RegWrite stays 0, count stays 0.
REQ-030 Two queued writes rd=7 (0xA then 0xB) under port_hold, rd_query1=7 -> pending1=1; with WB_BYPASS_EN fwd_data1=0xB, without fwd_valid1=0; pending1=0 after both drain.
REQ-031 rst asserted with 3 entries queued -> RegWrite, pending1/2 drop to 0 immediately (same cycle, no clock edge); no stale write after rst release.
